// File: rtl/mul8u_err_monitor.sv
// Error-statistics monitor for an 8x8 unsigned approximate multiplier.
// Three-stage pipeline: capture, exact-product/abs-error, accumulate (MAE/WCE/EP).
module mul8u_err_monitor #(
    parameter int CNT_W = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                clr,
    input  logic                in_valid,
    input  logic [7:0]          a,
    input  logic [7:0]          b,
    input  logic [15:0]         p_apx,
    output logic [CNT_W:0]      sample_cnt,
    output logic [CNT_W:0]      err_cnt,
    output logic [15+CNT_W:0]   sum_abs,
    output logic [15:0]         max_abs,
    output logic [7:0]          max_a,
    output logic [7:0]          max_b,
    output logic                full,
    output logic                busy
);

    localparam logic [CNT_W:0] LIMIT   = {1'b1, {CNT_W{1'b0}}};
    localparam logic [CNT_W:0] CNT_ONE = {{CNT_W{1'b0}}, 1'b1};

    // rst and clr have the same effect, so both collapse into one flush
    logic flush_s;

    // S1 capture registers
    logic        v1_d, v1_q;
    logic [7:0]  a1_d, a1_q;
    logic [7:0]  b1_d, b1_q;
    logic [15:0] p1_d, p1_q;

    // S2 error registers
    logic        v2_d, v2_q;
    logic [7:0]  a2_d, a2_q;
    logic [7:0]  b2_d, b2_q;
    logic [15:0] abs2_d, abs2_q;
    logic        nz2_d, nz2_q;
    logic [15:0] exact_s;
    logic [16:0] diff_s;
    logic [16:0] neg_s;
    logic [15:0] abs_s;

    // S3 statistics registers
    logic [CNT_W:0]    sample_cnt_d, sample_cnt_q;
    logic [CNT_W:0]    err_cnt_d, err_cnt_q;
    logic [15+CNT_W:0] sum_abs_d, sum_abs_q;
    logic [15:0]       max_abs_d, max_abs_q;
    logic [7:0]        max_a_d, max_a_q;
    logic [7:0]        max_b_d, max_b_q;
    logic              room_s;

    assign flush_s = rst | clr;

    // S1: capture the incoming sample; a flush drops the sample presented this cycle
    always_comb begin
        v1_d = 1'b0;
        a1_d = a1_q;
        b1_d = b1_q;
        p1_d = p1_q;
        if (flush_s) begin
            v1_d = 1'b0;
            a1_d = 8'd0;
            b1_d = 8'd0;
            p1_d = 16'd0;
        end else begin
            v1_d = in_valid;
            a1_d = a;
            b1_d = b;
            p1_d = p_apx;
        end
    end

    // S2: exact product and absolute error; both products are 16 bits so |diff| fits in 16
    always_comb begin
        exact_s = {8'd0, a1_q} * {8'd0, b1_q};
        diff_s  = {1'b0, p1_q} - {1'b0, exact_s};
        neg_s   = 17'd0 - diff_s;
        abs_s   = 16'd0;
        if (diff_s[16]) begin
            abs_s = neg_s[15:0];
        end else begin
            abs_s = diff_s[15:0];
        end
    end

    // S2 register inputs
    always_comb begin
        v2_d   = 1'b0;
        a2_d   = a2_q;
        b2_d   = b2_q;
        abs2_d = abs2_q;
        nz2_d  = nz2_q;
        if (flush_s) begin
            v2_d   = 1'b0;
            a2_d   = 8'd0;
            b2_d   = 8'd0;
            abs2_d = 16'd0;
            nz2_d  = 1'b0;
        end else begin
            v2_d   = v1_q;
            a2_d   = a1_q;
            b2_d   = b1_q;
            abs2_d = abs_s;
            nz2_d  = (abs_s != 16'd0);
        end
    end

    assign room_s = (sample_cnt_q < LIMIT);

    // S3: accumulate while below the limit; strict > keeps the first operands on ties
    always_comb begin
        sample_cnt_d = sample_cnt_q;
        err_cnt_d    = err_cnt_q;
        sum_abs_d    = sum_abs_q;
        max_abs_d    = max_abs_q;
        max_a_d      = max_a_q;
        max_b_d      = max_b_q;
        if (flush_s) begin
            sample_cnt_d = '0;
            err_cnt_d    = '0;
            sum_abs_d    = '0;
            max_abs_d    = 16'd0;
            max_a_d      = 8'd0;
            max_b_d      = 8'd0;
        end else if (v2_q && room_s) begin
            sample_cnt_d = sample_cnt_q + CNT_ONE;
            err_cnt_d    = err_cnt_q + (nz2_q ? CNT_ONE : {(CNT_W+1){1'b0}});
            sum_abs_d    = sum_abs_q + {{CNT_W{1'b0}}, abs2_q};
            if (abs2_q > max_abs_q) begin
                max_abs_d = abs2_q;
                max_a_d   = a2_q;
                max_b_d   = b2_q;
            end else begin
                max_abs_d = max_abs_q;
                max_a_d   = max_a_q;
                max_b_d   = max_b_q;
            end
        end else begin
            sample_cnt_d = sample_cnt_q;
        end
    end

    // Pipeline and statistics state register
    always_ff @(posedge clk) begin
        if (rst) begin
            v1_q         <= 1'b0;
            a1_q         <= 8'd0;
            b1_q         <= 8'd0;
            p1_q         <= 16'd0;
            v2_q         <= 1'b0;
            a2_q         <= 8'd0;
            b2_q         <= 8'd0;
            abs2_q       <= 16'd0;
            nz2_q        <= 1'b0;
            sample_cnt_q <= '0;
            err_cnt_q    <= '0;
            sum_abs_q    <= '0;
            max_abs_q    <= 16'd0;
            max_a_q      <= 8'd0;
            max_b_q      <= 8'd0;
        end else begin
            v1_q         <= v1_d;
            a1_q         <= a1_d;
            b1_q         <= b1_d;
            p1_q         <= p1_d;
            v2_q         <= v2_d;
            a2_q         <= a2_d;
            b2_q         <= b2_d;
            abs2_q       <= abs2_d;
            nz2_q        <= nz2_d;
            sample_cnt_q <= sample_cnt_d;
            err_cnt_q    <= err_cnt_d;
            sum_abs_q    <= sum_abs_d;
            max_abs_q    <= max_abs_d;
            max_a_q      <= max_a_d;
            max_b_q      <= max_b_d;
        end
    end

    assign sample_cnt = sample_cnt_q;
    assign err_cnt    = err_cnt_q;
    assign sum_abs    = sum_abs_q;
    assign max_abs    = max_abs_q;
    assign max_a      = max_a_q;
    assign max_b      = max_b_q;
    assign full       = (sample_cnt_q == LIMIT);
    assign busy       = v1_q | v2_q;

endmodule

// File: tb/tb_mul8u_err_monitor.sv
// Scoreboard bench for mul8u_err_monitor: a CNT_W=16 and a CNT_W=2 instance share one stimulus.
module tb_mul8u_err_monitor;

    logic        clk;
    logic        rst;
    logic        clr;
    logic        in_valid;
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] p_apx;

    logic [16:0] cnt16, err16;
    logic [31:0] sum16;
    logic [15:0] mx16;
    logic [7:0]  ma16, mb16;
    logic        full16, busy16;

    logic [2:0]  cnt2, err2;
    logic [17:0] sum2;
    logic [15:0] mx2;
    logic [7:0]  ma2, mb2;
    logic        full2, busy2;

    typedef struct {
        int unsigned a;
        int unsigned b;
        int unsigned err;
    } exp_t;

    exp_t    sb[$];
    int      n_tests;
    int      n_fail;
    int      lim[2];
    int      m_cnt[2];
    int      m_err[2];
    longint  m_sum[2];
    int      m_max[2];
    int      m_ma[2];
    int      m_mb[2];

    mul8u_err_monitor #(.CNT_W(16)) dut (
        .clk(clk), .rst(rst), .clr(clr), .in_valid(in_valid),
        .a(a), .b(b), .p_apx(p_apx),
        .sample_cnt(cnt16), .err_cnt(err16), .sum_abs(sum16), .max_abs(mx16),
        .max_a(ma16), .max_b(mb16), .full(full16), .busy(busy16)
    );

    mul8u_err_monitor #(.CNT_W(2)) dut_s (
        .clk(clk), .rst(rst), .clr(clr), .in_valid(in_valid),
        .a(a), .b(b), .p_apx(p_apx),
        .sample_cnt(cnt2), .err_cnt(err2), .sum_abs(sum2), .max_abs(mx2),
        .max_a(ma2), .max_b(mb2), .full(full2), .busy(busy2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int unsigned abs_err(input int ai, input int bi, input int pi);
        int d;
        d = pi - ai * bi;
        return (d < 0) ? -d : d;
    endfunction

    task automatic model_clear();
        for (int k = 0; k < 2; k++) begin
            m_cnt[k] = 0; m_err[k] = 0; m_sum[k] = 0;
            m_max[k] = 0; m_ma[k] = 0; m_mb[k] = 0;
        end
    endtask

    task automatic model_pop();
        exp_t e;
        e = sb.pop_front();
        for (int k = 0; k < 2; k++) begin
            if (m_cnt[k] < lim[k]) begin
                m_cnt[k]++;
                if (e.err != 0) m_err[k]++;
                m_sum[k] += e.err;
                if (int'(e.err) > m_max[k]) begin
                    m_max[k] = e.err; m_ma[k] = e.a; m_mb[k] = e.b;
                end
            end
        end
    endtask

    // One cycle of stimulus; returns 1 time unit after the edge that samples it
    task automatic drive(input int ai, input int bi, input int pi, input logic vi, input logic ci);
        exp_t e;
        a = 8'(ai); b = 8'(bi); p_apx = 16'(pi); in_valid = vi; clr = ci;
        if (ci) begin
            sb.delete();
            model_clear();
        end else if (vi) begin
            e.a = ai; e.b = bi; e.err = abs_err(ai, bi, pi);
            sb.push_back(e);
        end
        @(posedge clk); #1;
        in_valid = 1'b0; clr = 1'b0;
    endtask

    task automatic idle();
        drive(0, 0, 0, 1'b0, 1'b0);
    endtask

    task automatic drain(input string tag);
        int n;
        n = 0;
        while ((busy16 !== 1'b0 || busy2 !== 1'b0) && n < 8) begin
            @(posedge clk); #1;
            n++;
        end
        n_tests++;
        if (busy16 !== 1'b0 || busy2 !== 1'b0) begin
            n_fail++;
            $display("FAIL %s drain busy got %b/%b exp 0/0", tag, busy16, busy2);
        end
        while (sb.size() > 0) model_pop();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive(9, 9, 1, 1'b1, 1'b0);
        drive(9, 9, 1, 1'b1, 1'b0);
        sb.delete(); model_clear();
        n_tests++;
        if ({cnt16, err16, sum16, mx16, ma16, mb16, full16, busy16} !== '0 ||
            {cnt2, full2, busy2} !== '0) begin
            n_fail++;
            $display("FAIL reset outputs got cnt=%0d err=%0d sum=%0d max=%0d full=%b busy=%b exp all 0",
                     cnt16, err16, sum16, mx16, full16, busy16);
        end
        rst = 1'b0;
        idle();
        n_tests++;
        if (cnt16 !== 17'd0 || busy16 !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_release got cnt=%0d busy=%b exp 0/0", cnt16, busy16);
        end
    endtask

    task automatic test_exact();
        drive(10, 20, 200, 1'b1, 1'b0);
        n_tests++;
        if (busy16 !== 1'b1) begin
            n_fail++; $display("FAIL exact busy_s1 got %b exp 1", busy16);
        end
        idle();
        n_tests++;
        if (cnt16 !== 17'd0) begin
            n_fail++; $display("FAIL exact latency cycle2 cnt got %0d exp 0", cnt16);
        end
        idle();
        n_tests++;
        if (cnt16 !== 17'd1 || err16 !== 17'd0 || sum16 !== 32'd0 || mx16 !== 16'd0 ||
            ma16 !== 8'd0 || mb16 !== 8'd0) begin
            n_fail++;
            $display("FAIL exact cycle3 got cnt=%0d err=%0d sum=%0d max=%0d a=%0d b=%0d exp 1 0 0 0 0 0",
                     cnt16, err16, sum16, mx16, ma16, mb16);
        end
        drain("exact");
    endtask

    task automatic test_back_to_back();
        drive(0, 0, 0, 1'b0, 1'b1);
        drive(255, 255, 64911, 1'b1, 1'b0);
        drive(3, 3, 12, 1'b1, 1'b0);
        drain("b2b");
        n_tests++;
        if (cnt16 !== 17'(m_cnt[0]) || err16 !== 17'(m_err[0]) || sum16 !== 32'(m_sum[0])) begin
            n_fail++;
            $display("FAIL b2b counts got cnt=%0d err=%0d sum=%0d exp %0d %0d %0d",
                     cnt16, err16, sum16, m_cnt[0], m_err[0], m_sum[0]);
        end
        n_tests++;
        if (mx16 !== 16'(m_max[0]) || ma16 !== 8'(m_ma[0]) || mb16 !== 8'(m_mb[0])) begin
            n_fail++;
            $display("FAIL b2b max got %0d (%0d,%0d) exp %0d (%0d,%0d)",
                     mx16, ma16, mb16, m_max[0], m_ma[0], m_mb[0]);
        end
    endtask

    task automatic test_tie();
        drive(0, 0, 0, 1'b0, 1'b1);
        drive(7, 9, 68, 1'b1, 1'b0);
        drive(2, 5, 15, 1'b1, 1'b0);
        drain("tie");
        n_tests++;
        if (mx16 !== 16'(m_max[0]) || ma16 !== 8'(m_ma[0]) || mb16 !== 8'(m_mb[0]) ||
            err16 !== 17'(m_err[0])) begin
            n_fail++;
            $display("FAIL tie max got %0d (%0d,%0d) err=%0d exp %0d (%0d,%0d) err=%0d",
                     mx16, ma16, mb16, err16, m_max[0], m_ma[0], m_mb[0], m_err[0]);
        end
    endtask

    task automatic test_saturate();
        drive(0, 0, 0, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) drive(1, 1, 2, 1'b1, 1'b0);
        n_tests++;
        if (cnt2 !== 3'd3 || full2 !== 1'b0) begin
            n_fail++; $display("FAIL sat pre_limit got cnt=%0d full=%b exp 3 0", cnt2, full2);
        end
        idle();
        n_tests++;
        if (cnt2 !== 3'd4 || full2 !== 1'b1) begin
            n_fail++; $display("FAIL sat at_limit got cnt=%0d full=%b exp 4 1", cnt2, full2);
        end
        drain("sat");
        n_tests++;
        if (cnt2 !== 3'(m_cnt[1]) || err2 !== 3'(m_err[1]) || sum2 !== 18'(m_sum[1]) ||
            full2 !== 1'b1 || cnt16 !== 17'(m_cnt[0])) begin
            n_fail++;
            $display("FAIL sat final got cnt=%0d err=%0d sum=%0d full=%b cnt16=%0d exp %0d %0d %0d 1 %0d",
                     cnt2, err2, sum2, full2, cnt16, m_cnt[1], m_err[1], m_sum[1], m_cnt[0]);
        end
    endtask

    task automatic test_clr_mid();
        drive(0, 0, 0, 1'b0, 1'b1);
        drive(2, 5, 20, 1'b1, 1'b0);
        drive(2, 5, 20, 1'b1, 1'b0);
        drive(2, 5, 20, 1'b1, 1'b1);
        drive(2, 5, 13, 1'b1, 1'b0);
        idle();
        idle();
        n_tests++;
        if (busy16 !== 1'b0 || sum16 !== 32'd3 || cnt16 !== 17'd1) begin
            n_fail++;
            $display("FAIL clr_mid cycle6 got busy=%b sum=%0d cnt=%0d exp 0 3 1", busy16, sum16, cnt16);
        end
        drain("clr_mid");
        n_tests++;
        if (sum16 !== 32'(m_sum[0]) || cnt16 !== 17'(m_cnt[0]) || mx16 !== 16'(m_max[0])) begin
            n_fail++;
            $display("FAIL clr_mid model got sum=%0d cnt=%0d max=%0d exp %0d %0d %0d",
                     sum16, cnt16, mx16, m_sum[0], m_cnt[0], m_max[0]);
        end
    endtask

    task automatic test_sweep();
        drive(0, 0, 0, 1'b0, 1'b1);
        for (int ia = 0; ia < 256; ia++) begin
            for (int ib = 0; ib < 256; ib++) begin
                drive(ia, ib, ia * ib + ((ia == 255 && ib == 255) ? 1 : 0), 1'b1, 1'b0);
            end
        end
        drain("sweep");
        n_tests++;
        if (cnt16 !== 17'(m_cnt[0]) || full16 !== 1'b1 || err16 !== 17'(m_err[0]) ||
            sum16 !== 32'(m_sum[0]) || ma16 !== 8'(m_ma[0]) || mb16 !== 8'(m_mb[0])) begin
            n_fail++;
            $display("FAIL sweep got cnt=%0d full=%b err=%0d sum=%0d a=%0d b=%0d exp %0d 1 %0d %0d %0d %0d",
                     cnt16, full16, err16, sum16, ma16, mb16,
                     m_cnt[0], m_err[0], m_sum[0], m_ma[0], m_mb[0]);
        end
        drive(1, 1, 5, 1'b1, 1'b0);
        drain("post_full");
        n_tests++;
        if (cnt16 !== 17'(m_cnt[0]) || sum16 !== 32'(m_sum[0]) || mx16 !== 16'(m_max[0]) ||
            err16 !== 17'(m_err[0])) begin
            n_fail++;
            $display("FAIL post_full got cnt=%0d sum=%0d max=%0d err=%0d exp %0d %0d %0d %0d",
                     cnt16, sum16, mx16, err16, m_cnt[0], m_sum[0], m_max[0], m_err[0]);
        end
    endtask

    initial begin
        n_tests = 0; n_fail = 0;
        lim[0] = 65536; lim[1] = 4;
        model_clear();
        rst = 1'b0; clr = 1'b0; in_valid = 1'b0;
        a = 8'd0; b = 8'd0; p_apx = 16'd0;
        test_reset();
        test_exact();
        test_back_to_back();
        test_tie();
        test_saturate();
        test_clr_mid();
        test_sweep();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
